// File: rtl/serial_loader.sv
// Serial boot loader: receives a framed image over 8N1 UART, writes it to memory
// and holds the CPU in reset until a frame with a good checksum arrives.
module serial_loader #(
    parameter int BAUD_DIV = 217,
    parameter int TIMEOUT  = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        cpu_reset,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        loading,
    output logic        error
);

    localparam int HALF = BAUD_DIV / 2;
    localparam int BW   = $clog2(BAUD_DIV);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_H = 3'd1;
    localparam logic [2:0] S_ADDR_L = 3'd2;
    localparam logic [2:0] S_LEN_H  = 3'd3;
    localparam logic [2:0] S_LEN_L  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_CSUM   = 3'd6;

    logic          rx_meta, rxs, rxs_q;
    logic          busy;
    logic [BW-1:0] timer;
    logic [3:0]    bitn;
    logic [7:0]    rx_byte;
    logic          sample, byte_valid, frame_err;

    logic [2:0]    state;
    logic [15:0]   addr, count;
    logic [7:0]    sum, csum_total;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    // bitn: 0 = start check, 1..8 = data bits, 9 = stop bit
    assign sample     = busy && (timer == '0);
    assign byte_valid = sample && (bitn == 4'd9) && rxs;
    assign frame_err  = sample && (bitn == 4'd9) && !rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            timer   <= '0;
            bitn    <= '0;
            rx_byte <= '0;
        end else if (!busy) begin
            if (rxs_q && !rxs) begin
                busy  <= 1'b1;
                timer <= BW'(HALF - 1);
                bitn  <= '0;
            end
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end else begin
            timer <= BW'(BAUD_DIV - 1);
            bitn  <= bitn + 4'd1;
            if (bitn == 4'd0 && rxs)
                busy <= 1'b0;
            else if (bitn == 4'd9)
                busy <= 1'b0;
            else if (bitn != 4'd0)
                rx_byte <= {rxs, rx_byte[7:1]};
        end
    end

    assign csum_total = sum + rx_byte;
    assign loading    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            count     <= '0;
            sum       <= '0;
            tcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            if (state == S_IDLE) begin
                tcnt <= '0;
                // Idle without error and cpu_reset still high only happens right after reset.
                if (byte_valid && rx_byte == 8'h55) begin
                    state     <= S_ADDR_H;
                    cpu_reset <= 1'b1;
                    sum       <= '0;
                end else if (!error) begin
                    cpu_reset <= 1'b0;
                end
            end else if (frame_err || (!byte_valid && tcnt == TW'(TIMEOUT - 1))) begin
                state     <= S_IDLE;
                error     <= 1'b1;
                cpu_reset <= 1'b1;
                tcnt      <= '0;
            end else if (!byte_valid) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
                sum  <= csum_total;
                case (state)
                    S_ADDR_H: begin
                        addr[15:8] <= rx_byte;
                        state      <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        addr[7:0] <= rx_byte;
                        state     <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        count[15:8] <= rx_byte;
                        state       <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        count[7:0] <= rx_byte;
                        state      <= ({count[15:8], rx_byte} == 16'd0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr;
                        mem_data <= rx_byte;
                        addr     <= addr + 16'd1;
                        count    <= count - 16'd1;
                        if (count == 16'd1)
                            state <= S_CSUM;
                    end
                    S_CSUM: begin
                        state     <= S_IDLE;
                        error     <= (csum_total != 8'h00);
                        cpu_reset <= (csum_total != 8'h00);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_serial_loader;

    localparam int BAUD = 8;
    localparam int TMO  = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        cpu_reset, mem_we, loading, error;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    int checks = 0;
    int passed = 0;

    logic [23:0] wr_q[$];
    logic [23:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic        exp_good;
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    serial_loader #(.BAUD_DIV(BAUD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx(rx), .cpu_reset(cpu_reset), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .loading(loading), .error(error)
    );

    // Write monitor: record every write and require single-cycle strobes.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_data});
            checks++;
            if (we_prev) $display("FAIL we_pulse actual=multi-cycle required=single-cycle");
            else passed++;
        end
        we_prev = mem_we;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_period(input logic v);
        rx = v;
        tick(BAUD);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(stop);
        if (!stop) bit_period(1'b1);
    endtask

    task automatic send_frame;
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    endtask

    // Reference: what a frame should write and whether its checksum is good.
    task automatic build_model;
        logic [15:0] a, len;
        logic [7:0]  s;
        exp_q.delete();
        a = {frame_q[1], frame_q[2]};
        len = {frame_q[3], frame_q[4]};
        s = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
        for (int i = 0; i < int'(len); i++) exp_q.push_back({a + 16'(i), frame_q[5 + i]});
        exp_good = (s == 8'h00);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(5);
        checks++;
        if ({cpu_reset, mem_we, loading, error} !== 4'b1000)
            $display("FAIL reset_ctl actual=%b required=1000", {cpu_reset, mem_we, loading, error});
        else passed++;
        checks++;
        if ({mem_addr, mem_data} !== 24'h0)
            $display("FAIL reset_bus actual=%h required=000000", {mem_addr, mem_data});
        else passed++;
        reset = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1) $display("FAIL reset_hold actual=%b required=1", cpu_reset);
        else passed++;
        tick(1);
        checks++;
        if (cpu_reset !== 1'b0) $display("FAIL reset_release actual=%b required=0", cpu_reset);
        else passed++;
        tick(10);
    endtask

    task automatic test_basic;
        wr_q.delete();
        frame_q = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
        build_model();
        send_byte(frame_q[0], 1'b1);
        checks++;
        if ({loading, cpu_reset} !== 2'b11)
            $display("FAIL basic_header actual=%b required=11", {loading, cpu_reset});
        else passed++;
        for (int i = 1; i < 8; i++) send_byte(frame_q[i], 1'b1);
        checks++;
        if (cpu_reset !== 1'b1) $display("FAIL basic_hold actual=%b required=1", cpu_reset);
        else passed++;
        send_byte(frame_q[8], 1'b1);
        checks++;
        if (wr_q.size() != exp_q.size())
            $display("FAIL basic_count actual=%0d required=%0d", wr_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) $display("FAIL basic_wr%0d actual=%h required=%h", i, wr_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if ({cpu_reset, error, loading} !== 3'b000)
            $display("FAIL basic_done actual=%b required=000", {cpu_reset, error, loading});
        else passed++;
    endtask

    task automatic test_bad_then_recover;
        frame_q = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        build_model();
        send_frame();
        checks++;
        if ({error, cpu_reset, loading} !== {!exp_good, !exp_good, 1'b0})
            $display("FAIL badcsum actual=%b required=%b", {error, cpu_reset, loading}, {!exp_good, !exp_good, 1'b0});
        else passed++;
        wr_q.delete();
        frame_q = '{8'h55, 8'h12, 8'h34, 8'h00, 8'h00, 8'hBA};
        build_model();
        send_frame();
        checks++;
        if (wr_q.size() != 0) $display("FAIL recover_count actual=%0d required=0", wr_q.size());
        else passed++;
        checks++;
        if ({error, cpu_reset} !== 2'b00) $display("FAIL recover actual=%b required=00", {error, cpu_reset});
        else passed++;
    endtask

    task automatic test_wrap;
        wr_q.delete();
        frame_q = '{8'h55, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'hCD};
        build_model();
        send_frame();
        checks++;
        if (wr_q.size() != exp_q.size())
            $display("FAIL wrap_count actual=%0d required=%0d", wr_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) $display("FAIL wrap_wr%0d actual=%h required=%h", i, wr_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (error !== 1'b0) $display("FAIL wrap_err actual=%b required=0", error);
        else passed++;
    endtask

    task automatic test_idle_noise;
        wr_q.delete();
        send_byte(8'h00, 1'b1);
        checks++;
        if (loading !== 1'b0) $display("FAIL noise_00 actual=%b required=0", loading);
        else passed++;
        send_byte(8'hFF, 1'b1);
        checks++;
        if (loading !== 1'b0) $display("FAIL noise_ff actual=%b required=0", loading);
        else passed++;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * BAUD);
        checks++;
        if (loading !== 1'b0) $display("FAIL noise_glitch actual=%b required=0", loading);
        else passed++;
        send_byte(8'h55, 1'b0);
        checks++;
        if ({loading, error} !== 2'b00) $display("FAIL noise_stop actual=%b required=00", {loading, error});
        else passed++;
        checks++;
        if (wr_q.size() != 0) $display("FAIL noise_writes actual=%0d required=0", wr_q.size());
        else passed++;
    endtask

    task automatic test_aborts;
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        checks++;
        if (loading !== 1'b1) $display("FAIL tmo_loading actual=%b required=1", loading);
        else passed++;
        tick(TMO + 50);
        checks++;
        if ({error, loading, cpu_reset} !== 3'b101)
            $display("FAIL tmo_abort actual=%b required=101", {error, loading, cpu_reset});
        else passed++;
        frame_q = '{8'h55, 8'h12, 8'h34, 8'h00, 8'h00, 8'hBA};
        send_frame();
        checks++;
        if ({error, cpu_reset} !== 2'b00) $display("FAIL tmo_recover actual=%b required=00", {error, cpu_reset});
        else passed++;
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b0);
        checks++;
        if ({error, loading, cpu_reset} !== 3'b101)
            $display("FAIL ferr_abort actual=%b required=101", {error, loading, cpu_reset});
        else passed++;
        wr_q.delete();
        frame_q = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h05, 8'hAA, 8'hBB};
        send_frame();
        checks++;
        if ({wr_q.size() == 2, loading} !== 2'b11)
            $display("FAIL rst_mid_pre actual=%0d,%b required=2,1", wr_q.size(), loading);
        else passed++;
        reset = 1'b1;
        tick(2);
        checks++;
        if ({error, loading, cpu_reset, mem_we} !== 4'b0010)
            $display("FAIL rst_mid actual=%b required=0010", {error, loading, cpu_reset, mem_we});
        else passed++;
        reset = 1'b0;
        tick(1);
        checks++;
        if (cpu_reset !== 1'b0) $display("FAIL rst_mid_release actual=%b required=0", cpu_reset);
        else passed++;
        tick(10);
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 6; f++) begin
            logic [7:0]  s, ah, al, len;
            logic        good;
            ah = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            al = ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom);
            len = 8'($urandom_range(0, 5));
            good = 1'($urandom_range(0, 1));
            frame_q = '{8'h55, ah, al, 8'h00, len};
            for (int i = 0; i < int'(len); i++) frame_q.push_back(8'($urandom));
            s = 8'h00;
            for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
            frame_q.push_back(good ? 8'(-s) : 8'(-s) + 8'($urandom_range(1, 255)));
            build_model();
            wr_q.delete();
            send_frame();
            checks++;
            if (wr_q.size() != exp_q.size())
                $display("FAIL rand%0d_count actual=%0d required=%0d", f, wr_q.size(), exp_q.size());
            else passed++;
            for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) $display("FAIL rand%0d_wr%0d actual=%h required=%h", f, i, wr_q[i], exp_q[i]);
                else passed++;
            end
            checks++;
            if ({error, cpu_reset, loading} !== {!exp_good, !exp_good, 1'b0})
                $display("FAIL rand%0d_status actual=%b required=%b", f, {error, cpu_reset, loading}, {!exp_good, !exp_good, 1'b0});
            else passed++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_bad_then_recover();
        test_wrap();
        test_idle_noise();
        test_aborts();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
